// File: rtl/shift_pack_pkg.sv
// Shared types and helpers for the shift/pack controller: beat geometry,
// per-beat shift metadata and the output-side state encoding.
package shift_pack_pkg;

  localparam int WIDTH        = 512;
  localparam int BYTES        = WIDTH / 8;
  localparam int OFFSET_WIDTH = $clog2(BYTES);

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] offset;
    logic [OFFSET_WIDTH:0]   count;
    logic                    last;
  } shift_meta_t;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  function automatic logic [OFFSET_WIDTH:0] keep_count(input logic [BYTES-1:0] keep);
    logic [OFFSET_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < BYTES; i++) c = c + {{OFFSET_WIDTH{1'b0}}, keep[i]};
    return c;
  endfunction

  function automatic logic [BYTES-1:0] low_mask(input logic [OFFSET_WIDTH+1:0] cnt);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (i < int'(cnt));
    return m;
  endfunction

endpackage

// File: rtl/shift_pack_controller_fifo.sv
// First-word-fall-through FIFO carrying shift metadata alongside the shifter
// latency. A push on full or a pop on empty is ignored.
module shift_meta_fifo
  import shift_pack_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  shift_meta_t din,
  input  logic        pop,
  output shift_meta_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  shift_meta_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/shift_pack_controller.sv
// Packs partially filled beats into dense beats via an external byte rotator.
// Define SHIFT_PACK_STATS_EN to build the byte/beat statistics counters.
module shift_pack_controller
  import shift_pack_pkg::*;
#(
  parameter int META_DEPTH = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [WIDTH-1:0]        i_data_tdata,
  input  logic [BYTES-1:0]        i_data_tkeep,
  input  logic                    i_data_tlast,
  input  logic                    i_data_tvalid,
  output logic                    i_data_tready,
  output logic [WIDTH-1:0]        o_data_tdata,
  output logic [BYTES-1:0]        o_data_tkeep,
  output logic                    o_data_tlast,
  output logic                    o_data_tvalid,
  input  logic                    o_data_tready,
  output logic [OFFSET_WIDTH-1:0] shf_offset,
  output logic [WIDTH-1:0]        shf_in_tdata,
  output logic                    shf_in_tvalid,
  input  logic                    shf_in_tready,
  input  logic [WIDTH-1:0]        shf_out_tdata,
  input  logic                    shf_out_tvalid,
  output logic                    shf_out_tready,
  output logic [31:0]             stat_bytes_in,
  output logic [31:0]             stat_beats_out
);

  localparam logic [OFFSET_WIDTH+1:0] FULL_FILL = (OFFSET_WIDTH+2)'(BYTES);

  logic                    live;
  logic [OFFSET_WIDTH-1:0] fi;
  logic [OFFSET_WIDTH:0]   in_n;
  logic                    meta_full, meta_empty, in_hs, out_hs, slot_free;
  shift_meta_t             meta_push, meta_head;

  // Input side: combinational pass-through to the shifter
  assign in_n          = keep_count(i_data_tkeep);
  assign shf_in_tdata  = i_data_tdata;
  assign shf_offset    = fi;
  assign shf_in_tvalid = live && i_data_tvalid && !meta_full;
  assign i_data_tready = live && shf_in_tready && !meta_full;
  assign in_hs         = i_data_tvalid && i_data_tready;
  assign meta_push     = '{offset: fi, count: in_n, last: i_data_tlast};

  shift_meta_fifo #(.DEPTH(META_DEPTH)) u_meta_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (in_hs),
    .din   (meta_push),
    .pop   (out_hs),
    .dout  (meta_head),
    .full  (meta_full),
    .empty (meta_empty)
  );

  state_t                  state_p0, nxt_state;
  logic [OFFSET_WIDTH-1:0] fa_p0, nxt_fa;
  logic [WIDTH-1:0]        acc_p0, nxt_acc, merged;
  logic [OFFSET_WIDTH+1:0] fill_end;
  logic                    emit, emit_last;
  logic [WIDTH-1:0]        emit_data;
  logic [BYTES-1:0]        emit_keep;
  logic                    out_vld_p1, out_last_p1;
  logic [WIDTH-1:0]        out_data_p1;
  logic [BYTES-1:0]        out_keep_p1;

  assign slot_free      = !out_vld_p1 || o_data_tready;
  assign shf_out_tready = live && (state_p0 == ST_RUN) && slot_free && !meta_empty;
  assign out_hs         = shf_out_tvalid && shf_out_tready;
  assign fill_end       = {2'b00, meta_head.offset} + {1'b0, meta_head.count};

  // Shifted bytes land in [F, s); bytes below F are the accumulated fill
  always_comb begin
    merged = acc_p0;
    for (int j = 0; j < BYTES; j++)
      if (j >= int'(meta_head.offset) && j < int'(fill_end))
        merged[8*j +: 8] = shf_out_tdata[8*j +: 8];
  end

  always_comb begin
    nxt_state = state_p0;
    nxt_fa    = fa_p0;
    nxt_acc   = acc_p0;
    emit      = 1'b0;
    emit_data = merged;
    emit_keep = '1;
    emit_last = 1'b0;
    case (state_p0)
      ST_RUN: begin
        if (out_hs) begin
          if (fill_end >= FULL_FILL) begin
            // Wrapped bytes already sit at the bottom of the rotated word
            emit      = 1'b1;
            emit_last = meta_head.last && (fill_end == FULL_FILL);
            nxt_acc   = shf_out_tdata;
            nxt_fa    = fill_end[OFFSET_WIDTH-1:0];
            if (meta_head.last && fill_end > FULL_FILL) nxt_state = ST_FLUSH;
          end else begin
            nxt_acc = merged;
            if (meta_head.last) begin
              emit      = (fill_end != '0);
              emit_keep = low_mask(fill_end);
              emit_last = 1'b1;
              nxt_fa    = '0;
            end else begin
              nxt_fa = fill_end[OFFSET_WIDTH-1:0];
            end
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_data = acc_p0;
          emit_keep = low_mask({2'b00, fa_p0});
          emit_last = 1'b1;
          nxt_fa    = '0;
          nxt_state = ST_RUN;
        end
      end
      default: nxt_state = ST_RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_p0 <= ST_RUN;
    else          state_p0 <= nxt_state;
  end

  // Output register stage; payload only reloads when the slot is free
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live        <= 1'b0;
      fi          <= '0;
      fa_p0       <= '0;
      acc_p0      <= '0;
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_keep_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else begin
      live   <= 1'b1;
      fa_p0  <= nxt_fa;
      acc_p0 <= nxt_acc;
      if (in_hs) fi <= i_data_tlast ? '0 : fi + in_n[OFFSET_WIDTH-1:0];
      if (emit) begin
        out_vld_p1  <= 1'b1;
        out_data_p1 <= emit_data;
        out_keep_p1 <= emit_keep;
        out_last_p1 <= emit_last;
      end else if (o_data_tready) begin
        out_vld_p1 <= 1'b0;
      end
    end
  end

  assign o_data_tvalid = out_vld_p1;
  assign o_data_tdata  = out_data_p1;
  assign o_data_tkeep  = out_keep_p1;
  assign o_data_tlast  = out_last_p1;

`ifdef SHIFT_PACK_STATS_EN
  logic [31:0] bytes_cnt, beats_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bytes_cnt <= '0;
      beats_cnt <= '0;
    end else begin
      if (in_hs) bytes_cnt <= bytes_cnt + 32'(in_n);
      if (out_vld_p1 && o_data_tready) beats_cnt <= beats_cnt + 32'd1;
    end
  end

  assign stat_bytes_in  = bytes_cnt;
  assign stat_beats_out = beats_cnt;
`else
  assign stat_bytes_in  = '0;
  assign stat_beats_out = '0;
`endif

endmodule

// File: tb/tb_shift_pack_controller.sv
// Bench for shift_pack_controller: latency-3 rotating shifter model, byte-stream
// reference packer feeding an expected-beat scoreboard.
`timescale 1ns/1ps
module tb_shift_pack_controller;
  import shift_pack_pkg::*;

  localparam int LAT = 3;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [WIDTH-1:0]        i_data_tdata;
  logic [BYTES-1:0]        i_data_tkeep;
  logic                    i_data_tlast, i_data_tvalid, i_data_tready;
  logic [WIDTH-1:0]        o_data_tdata;
  logic [BYTES-1:0]        o_data_tkeep;
  logic                    o_data_tlast, o_data_tvalid, o_data_tready;
  logic [OFFSET_WIDTH-1:0] shf_offset;
  logic [WIDTH-1:0]        shf_in_tdata, shf_out_tdata;
  logic                    shf_in_tvalid, shf_in_tready, shf_out_tvalid, shf_out_tready;
  logic [31:0]             stat_bytes_in, stat_beats_out;

  always #5 aclk = ~aclk;

  shift_pack_controller #(.META_DEPTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_data_tdata(i_data_tdata), .i_data_tkeep(i_data_tkeep), .i_data_tlast(i_data_tlast),
    .i_data_tvalid(i_data_tvalid), .i_data_tready(i_data_tready),
    .o_data_tdata(o_data_tdata), .o_data_tkeep(o_data_tkeep), .o_data_tlast(o_data_tlast),
    .o_data_tvalid(o_data_tvalid), .o_data_tready(o_data_tready),
    .shf_offset(shf_offset),
    .shf_in_tdata(shf_in_tdata), .shf_in_tvalid(shf_in_tvalid), .shf_in_tready(shf_in_tready),
    .shf_out_tdata(shf_out_tdata), .shf_out_tvalid(shf_out_tvalid), .shf_out_tready(shf_out_tready),
    .stat_bytes_in(stat_bytes_in), .stat_beats_out(stat_beats_out)
  );

  typedef struct { logic [WIDTH-1:0] data; logic [BYTES-1:0] keep; logic last; } beat_t;
  typedef struct { logic [WIDTH-1:0] data; int t; } shf_ent_t;

  beat_t      exp_q[$];
  shf_ent_t   shf_q[$];
  logic [7:0] ref_bytes[$];
  int checks = 0, errors = 0, cyc = 0, bubble_cnt = 0, model_fi = 0;
  int exp_bytes_in = 0, exp_beats_out = 0;
  bit bp_en = 1'b0;

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkk(input string tag, input logic [BYTES-1:0] obs, input logic [BYTES-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] byte_mask(input logic [BYTES-1:0] keep);
    logic [WIDTH-1:0] m;
    for (int b = 0; b < BYTES; b++) m[8*b +: 8] = {8{keep[b]}};
    return m;
  endfunction

  // Reference packer: concatenate valid bytes, cut into dense beats
  task automatic push_ref(input logic [WIDTH-1:0] d, input int n, input bit last);
    beat_t e;
    for (int b = 0; b < n; b++) ref_bytes.push_back(d[8*b +: 8]);
    while (ref_bytes.size() >= BYTES) begin
      e.data = '0;
      for (int b = 0; b < BYTES; b++) e.data[8*b +: 8] = ref_bytes.pop_front();
      e.keep = '1;
      e.last = last && (ref_bytes.size() == 0);
      exp_q.push_back(e);
      exp_beats_out++;
    end
    if (last && ref_bytes.size() > 0) begin
      e.data = '0;
      e.keep = '0;
      for (int b = 0; ref_bytes.size() > 0; b++) begin
        e.data[8*b +: 8] = ref_bytes.pop_front();
        e.keep[b] = 1'b1;
      end
      e.last = 1'b1;
      exp_q.push_back(e);
      exp_beats_out++;
    end
  endtask

  task automatic send(input int n, input bit last);
    logic [WIDTH-1:0] d;
    logic [BYTES-1:0] k;
    int guard;
    for (int b = 0; b < BYTES; b++) begin
      d[8*b +: 8] = 8'($urandom);
      k[b] = (b < n);
    end
    i_data_tdata  = d;
    i_data_tkeep  = k;
    i_data_tlast  = last;
    i_data_tvalid = 1'b1;
    guard = 0;
    @(negedge aclk);
    while (!i_data_tready && guard < 200) begin
      guard++;
      @(negedge aclk);
    end
    if (!i_data_tready) begin
      checki("send_timeout", 0, 1);
    end else begin
      checki("shf_offset", int'(shf_offset), model_fi);
      checki("shf_in_tvalid", int'(shf_in_tvalid), 1);
      push_ref(d, n, last);
      exp_bytes_in += n;
      model_fi = last ? 0 : (model_fi + n) % BYTES;
    end
    @(posedge aclk); #1;
    i_data_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((exp_q.size() > 0 || shf_q.size() > 0) && guard < 2000) begin
      @(posedge aclk);
      guard++;
    end
    repeat (4) @(posedge aclk);
    #1;
    checki({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checki({tag, "_o_tvalid"}, int'(o_data_tvalid), 0);
    checkw({tag, "_o_tdata"}, o_data_tdata, '0);
    checkk({tag, "_o_tkeep"}, o_data_tkeep, '0);
    checki({tag, "_o_tlast"}, int'(o_data_tlast), 0);
    checki({tag, "_shf_in_tvalid"}, int'(shf_in_tvalid), 0);
    checki({tag, "_shf_offset"}, int'(shf_offset), 0);
    checki({tag, "_i_tready"}, int'(i_data_tready), 0);
    checki({tag, "_shf_out_tready"}, int'(shf_out_tready), 0);
    checki({tag, "_stat_bytes"}, int'(stat_bytes_in), 0);
    checki({tag, "_stat_beats"}, int'(stat_beats_out), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef SHIFT_PACK_STATS_EN
    checki({tag, "_stat_bytes"}, int'(stat_bytes_in), exp_bytes_in);
    checki({tag, "_stat_beats"}, int'(stat_beats_out), exp_beats_out);
`else
    checki({tag, "_stat_bytes"}, int'(stat_bytes_in), 0);
    checki({tag, "_stat_beats"}, int'(stat_beats_out), 0);
`endif
  endtask

  // Shifter model: in-order, fixed latency, rotate left by offset bytes
  initial begin
    logic [WIDTH-1:0] rot;
    bit ih, oh;
    shf_out_tvalid = 1'b0;
    shf_out_tdata  = '0;
    forever begin
      @(negedge aclk);
      ih = shf_in_tvalid && shf_in_tready;
      oh = shf_out_tvalid && shf_out_tready;
      if (aresetn && shf_out_tvalid && !shf_out_tready) bubble_cnt++;
      for (int j = 0; j < BYTES; j++)
        rot[8*j +: 8] = shf_in_tdata[8*((j - int'(shf_offset) + BYTES) % BYTES) +: 8];
      @(posedge aclk); #1;
      cyc++;
      if (!aresetn) begin
        shf_q.delete();
      end else begin
        if (oh) void'(shf_q.pop_front());
        if (ih) shf_q.push_back('{rot, cyc});
      end
      if (shf_q.size() > 0 && cyc - shf_q[0].t >= LAT - 1) begin
        shf_out_tvalid = 1'b1;
        shf_out_tdata  = shf_q[0].data;
      end else begin
        shf_out_tvalid = 1'b0;
      end
    end
  end

  // Output monitor, scoreboard pop and AXI hold-stable rule
  initial begin
    beat_t e, held;
    bit held_v;
    logic [WIDTH-1:0] m;
    held_v = 1'b0;
    o_data_tready = 1'b1;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          checki("hold_tvalid", int'(o_data_tvalid), 1);
          checkw("hold_tdata", o_data_tdata, held.data);
          checkk("hold_tkeep", o_data_tkeep, held.keep);
          checki("hold_tlast", int'(o_data_tlast), int'(held.last));
        end
        held_v    = o_data_tvalid && !o_data_tready;
        held.data = o_data_tdata;
        held.keep = o_data_tkeep;
        held.last = o_data_tlast;
        if (o_data_tvalid && o_data_tready) begin
          checki("out_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = byte_mask(e.keep);
            checkk("out_tkeep", o_data_tkeep, e.keep);
            checki("out_tlast", int'(o_data_tlast), int'(e.last));
            checkw("out_tdata", o_data_tdata & m, e.data & m);
          end
        end
      end
      @(posedge aclk); #1;
      o_data_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit last;
    int n;
    i_data_tdata  = '0;
    i_data_tkeep  = '0;
    i_data_tlast  = 1'b0;
    i_data_tvalid = 1'b1;
    shf_in_tready = 1'b1;
    aresetn       = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("init");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    i_data_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    for (int i = 0; i < 4; i++) send(16, i == 3);
    drain("quad16");

    bubble_cnt = 0;
    send(40, 1'b0);
    send(40, 1'b1);
    send(4, 1'b1);
    drain("flush");
    checki("flush_bubble", bubble_cnt, 1);

    send(10, 1'b1);
    send(5, 1'b1);
    drain("two_pkts");

    send(0, 1'b1);
    drain("empty_pkt");
    send(8, 1'b0);
    send(0, 1'b1);
    drain("empty_tail");

    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      last = ($urandom_range(0, 3) == 0) || (i == 299);
      n = last ? int'($urandom_range(0, BYTES)) : int'($urandom_range(1, BYTES));
      send(n, last);
    end
    bp_en = 1'b0;
    drain("random");
    check_stats("random");

    send(30, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    i_data_tvalid = 1'b1;
    exp_q.delete();
    ref_bytes.delete();
    model_fi = 0;
    exp_bytes_in = 0;
    exp_beats_out = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("midrst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    i_data_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    send(64, 1'b1);
    drain("post_rst");
    check_stats("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
